// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: shares one push/pop FIFO among NREQ producers and a single
// consumer. Producer pushes are arbitrated and interleaved with consumer pops;
// at most one FIFO operation is issued per cycle. Occupancy is tracked locally
// and any disagreement with the FIFO's full/empty flags raises a sticky error.
//
// Build option: define FIFO_SHARE_FIXED_PRIO_EN for fixed-priority push
// selection (lowest index wins). Otherwise selection is round-robin.
//
// Ports:
//   clock, reset_n   clock (rising edge), async active-low reset
//   req              per-producer push request
//   reqData          producer k data at [k*(MSBD+1) +: MSBD+1]
//   gnt              one-hot grant, producer pushed this cycle
//   popReq, popAck   consumer pop request / pop issued this cycle
//   fifoPush/Pop     FIFO command strobes
//   fifoDataIn       FIFO write data, holds between pushes
//   fifoFull/Empty   FIFO status flags
//   count            tracked occupancy 0..LAST+1
//   mismatch         sticky flag: FIFO flags disagree with count
module fifo_share_ctrl #(
  parameter int unsigned MSBD = 3,
  parameter int unsigned LAST = 4,
  parameter int unsigned MSBA = 3,
  parameter int unsigned NREQ = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*(MSBD+1)-1:0] reqData,
  output logic [NREQ-1:0]          gnt,
  input  logic                     popReq,
  output logic                     popAck,
  output logic                     fifoPush,
  output logic                     fifoPop,
  output logic [MSBD:0]            fifoDataIn,
  input  logic                     fifoFull,
  input  logic                     fifoEmpty,
  output logic [MSBA+1:0]          count,
  output logic                     mismatch
);

  localparam int unsigned DW = MSBD + 1;
  localparam int unsigned CW = MSBA + 2;
  localparam logic [CW-1:0] CNT_FULL = CW'(LAST + 1);

  // Encoding keeps push/pop strobes as direct state flop bits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PUSH = 2'b01,
    ST_POP  = 2'b10
  } state_e;

  typedef enum logic {
    OP_POP  = 1'b0,
    OP_PUSH = 1'b1
  } op_e;

  state_e         state_q, state_d;
  op_e            last_op_q, last_op_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic [CW-1:0]  count_q, count_d;
  logic           mismatch_q, mismatch_d;

  logic [NREQ-1:0] elig;
  logic            push_cand;
  logic            pop_cand;
  logic            found;
  int unsigned     sel;

`ifndef FIFO_SHARE_FIXED_PRIO_EN
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PTR_W-1:0] rr_q, rr_d;
`endif

  // Next-state, arbitration and occupancy tracking.
  always_comb begin
    state_d    = ST_IDLE;
    last_op_d  = last_op_q;
    gnt_d      = '0;
    data_d     = data_q;
    count_d    = count_q;
    found      = 1'b0;
    sel        = 0;
`ifndef FIFO_SHARE_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif

    // Occupancy after the operation issued this cycle takes effect.
    if (state_q == ST_PUSH) begin
      count_d = count_q + CW'(1);
    end else if (state_q == ST_POP) begin
      count_d = count_q - CW'(1);
    end

    mismatch_d = mismatch_q
               | (fifoFull  != (count_q == CNT_FULL))
               | (fifoEmpty != (count_q == '0));

    // Gate on projected occupancy so an in-flight op cannot over/underflow.
    elig      = req & ~gnt_q;
    push_cand = (|elig) && (count_d != CNT_FULL);
    pop_cand  = popReq && (count_d != '0) && (state_q != ST_POP);

`ifdef FIFO_SHARE_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && elig[k]) begin
        found = 1'b1;
        sel   = k;
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!found && elig[k] && (k == (32'(rr_q) + i) % NREQ)) begin
          found = 1'b1;
          sel   = k;
        end
      end
    end
`endif

    if (push_cand && pop_cand) begin
      state_d = (last_op_q == OP_PUSH) ? ST_POP : ST_PUSH;
    end else if (push_cand) begin
      state_d = ST_PUSH;
    end else if (pop_cand) begin
      state_d = ST_POP;
    end

    case (state_d)
      ST_PUSH: begin
        last_op_d = OP_PUSH;
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (k == sel) begin
            gnt_d[k] = 1'b1;
            data_d   = reqData[k*DW +: DW];
          end
        end
`ifndef FIFO_SHARE_FIXED_PRIO_EN
        rr_d = PTR_W'((sel + 1) % NREQ);
`endif
      end
      ST_POP: begin
        last_op_d = OP_POP;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      last_op_q  <= OP_POP;
      gnt_q      <= '0;
      data_q     <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
`ifndef FIFO_SHARE_FIXED_PRIO_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_op_q  <= last_op_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
`ifndef FIFO_SHARE_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign fifoPush   = state_q[0];
  assign fifoPop    = state_q[1];
  assign popAck     = state_q[1];
  assign fifoDataIn = data_q;
  assign count      = count_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed self-checking bench for fifo_share_ctrl (default round-robin build).
// A small occupancy model stands in for the FIFO and supplies full/empty.
module tb_fifo_share_ctrl;

  logic       clock;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] reqData;
  logic [1:0] gnt;
  logic       popReq;
  logic       popAck;
  logic       fifoPush;
  logic       fifoPop;
  logic [3:0] fifoDataIn;
  logic       fifoFull;
  logic       fifoEmpty;
  logic [4:0] count;
  logic       mismatch;

  logic [4:0] occ;
  logic       force_not_empty;

  int errors;
  int checks;

  fifo_share_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .reqData    (reqData),
    .gnt        (gnt),
    .popReq     (popReq),
    .popAck     (popAck),
    .fifoPush   (fifoPush),
    .fifoPop    (fifoPop),
    .fifoDataIn (fifoDataIn),
    .fifoFull   (fifoFull),
    .fifoEmpty  (fifoEmpty),
    .count      (count),
    .mismatch   (mismatch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in FIFO occupancy, reset together with the controller.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) occ <= '0;
    else if (fifoPush) occ <= occ + 5'd1;
    else if (fifoPop) occ <= occ - 5'd1;
  end
  assign fifoFull  = (occ == 5'd5);
  assign fifoEmpty = (occ == 5'd0) & ~force_not_empty;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n         = 1'b0;
    req             = 2'b00;
    popReq          = 1'b0;
    force_not_empty = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  logic [1:0] exp_gnt8 [8];
  logic [4:0] exp_cnt8 [8];
  logic [1:0] exp_gnt6 [6];
  logic       exp_ack6 [6];
  logic [4:0] exp_cnt6 [6];
  logic [1:0] exp_gnt4 [4];
  logic       exp_ack4 [4];
  logic [4:0] exp_cnt4 [4];

  initial begin
    errors  = 0;
    checks  = 0;
    reqData = {4'h5, 4'hA};
    exp_gnt8 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    exp_cnt8 = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd5};
    exp_gnt6 = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    exp_ack6 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_cnt6 = '{5'd5, 5'd4, 5'd5, 5'd4, 5'd5, 5'd4};
    exp_gnt4 = '{2'b01, 2'b00, 2'b10, 2'b00};
    exp_ack4 = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_cnt4 = '{5'd0, 5'd1, 5'd0, 5'd1};

    // Reset values and a single push.
    apply_reset();
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_push", 32'(fifoPush), 32'd0);
    check_eq("rst_pop", 32'(fifoPop), 32'd0);
    check_eq("rst_ack", 32'(popAck), 32'd0);
    check_eq("rst_data", 32'(fifoDataIn), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_mismatch", 32'(mismatch), 32'd0);
    req = 2'b01;
    tick();
    check_eq("single_gnt", 32'(gnt), 32'h1);
    check_eq("single_push", 32'(fifoPush), 32'd1);
    check_eq("single_data", 32'(fifoDataIn), 32'hA);
    check_eq("single_count_before", 32'(count), 32'd0);
    req = 2'b00;
    tick();
    check_eq("single_count_after", 32'(count), 32'd1);
    check_eq("single_gnt_off", 32'(gnt), 32'd0);
    check_eq("data_hold", 32'(fifoDataIn), 32'hA);

    // Two producers, no pops: alternate until full, then idle.
    apply_reset();
    req = 2'b11;
    for (int t = 0; t < 8; t++) begin
      tick();
      check_eq($sformatf("fill_gnt%0d", t), 32'(gnt), 32'(exp_gnt8[t]));
      check_eq($sformatf("fill_cnt%0d", t), 32'(count), 32'(exp_cnt8[t]));
      if (exp_gnt8[t] == 2'b01) check_eq($sformatf("fill_data%0d", t), 32'(fifoDataIn), 32'hA);
      if (exp_gnt8[t] == 2'b10) check_eq($sformatf("fill_data%0d", t), 32'(fifoDataIn), 32'h5);
    end

    // Full FIFO with pops requested: pop/push alternate around capacity.
    popReq = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check_eq($sformatf("full_gnt%0d", t), 32'(gnt), 32'(exp_gnt6[t]));
      check_eq($sformatf("full_ack%0d", t), 32'(popAck), 32'(exp_ack6[t]));
      check_eq($sformatf("full_fpop%0d", t), 32'(fifoPop), 32'(exp_ack6[t]));
      check_eq($sformatf("full_cnt%0d", t), 32'(count), 32'(exp_cnt6[t]));
    end
    check_eq("full_no_mismatch", 32'(mismatch), 32'd0);

    // Empty: pop requests are never acknowledged.
    apply_reset();
    popReq = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      check_eq($sformatf("empty_ack%0d", t), 32'(popAck), 32'd0);
      check_eq($sformatf("empty_fpop%0d", t), 32'(fifoPop), 32'd0);
    end

    // Simultaneous push and pop candidates after a push resolve to pop.
    apply_reset();
    req    = 2'b11;
    popReq = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      check_eq($sformatf("mix_gnt%0d", t), 32'(gnt), 32'(exp_gnt4[t]));
      check_eq($sformatf("mix_ack%0d", t), 32'(popAck), 32'(exp_ack4[t]));
      check_eq($sformatf("mix_cnt%0d", t), 32'(count), 32'(exp_cnt4[t]));
    end

    // Flag disagreement sets a sticky error cleared only by reset.
    apply_reset();
    force_not_empty = 1'b1;
    tick();
    check_eq("mm_set", 32'(mismatch), 32'd1);
    force_not_empty = 1'b0;
    tick();
    check_eq("mm_sticky", 32'(mismatch), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mm_clear", 32'(mismatch), 32'd0);

    // Reset asserted during a push cycle clears outputs immediately.
    apply_reset();
    req = 2'b11;
    repeat (3) tick();
    check_eq("midrst_pre_push", 32'(fifoPush), 32'd1);
    check_eq("midrst_pre_cnt", 32'(count), 32'd2);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_gnt", 32'(gnt), 32'd0);
    check_eq("midrst_push", 32'(fifoPush), 32'd0);
    check_eq("midrst_cnt", 32'(count), 32'd0);
    reset_n = 1'b1;
    req     = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
